// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared constants and types for the HI/LO multiply/divide issue controller.
// R-type funct encodings, default busy latencies, FSM state type and the
// instruction class bundle produced by md_class.
package muldiv_issue_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1a;
   localparam logic [5:0] F_DIVU  = 6'h1b;

   localparam int MD_MUL_CYCLES = 5;
   localparam int MD_DIV_CYCLES = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   typedef struct packed {
      logic is_md_op;   // mult/multu/div/divu
      logic is_mul;     // mult/multu
      logic is_hl_acc;  // any HI/LO access, including the md ops
   } md_class_t;

endpackage

// File: rtl/muldiv_issue_ctrl_md_class.sv
// Combinational instruction classifier for the muldiv issue path.
// Ports:
//   instr  in  32  instruction word
//   cls    out     {is_md_op, is_mul, is_hl_acc}
module md_class
   import muldiv_issue_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output md_class_t   cls
);

   logic [5:0] op;
   logic [5:0] funct;
   logic       unused_bits;

   assign op          = instr[31:26];
   assign funct       = instr[5:0];
   assign unused_bits = ^instr[25:6];

   always_comb begin
      cls = '0;
      if (op == OP_RTYPE) begin
         case (funct)
            F_MULT, F_MULTU: cls = '{is_md_op: 1'b1, is_mul: 1'b1, is_hl_acc: 1'b1};
            F_DIV, F_DIVU:   cls = '{is_md_op: 1'b1, is_mul: 1'b0, is_hl_acc: 1'b1};
            F_MFHI, F_MFLO,
            F_MTHI, F_MTLO:  cls = '{is_md_op: 1'b0, is_mul: 1'b0, is_hl_acc: 1'b1};
            default:         cls = '0;
         endcase
      end
   end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// E-stage initiator for the HI/LO multiply/divide unit.
// Issues one start per mult/div instance, shadows the unit's busy window with
// a down-counter, stalls D on HI/LO-class instructions while the unit is in
// use, and raises a sticky error when md_busy disagrees with the shadow.
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   E_instr    in   32  E-stage instruction
//   E_valid    in   1   E holds a real instruction
//   E_hold     in   1   E register keeps its contents this cycle
//   D_instr    in   32  D-stage instruction
//   Req        in   1   exception/interrupt request, cancels E side effects
//   md_busy    in   1   busy from the muldiv unit
//   md_start   out  1   start pulse to the muldiv unit
//   md_instr   out  32  instruction to the muldiv unit, zero when gated
//   stall_D    out  1   stall D/F this cycle
//   proto_err  out  1   sticky busy/latency mismatch
module muldiv_issue_ctrl
   import muldiv_issue_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = MD_MUL_CYCLES,
   parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] E_instr,
   input  logic        E_valid,
   input  logic        E_hold,
   input  logic [31:0] D_instr,
   input  logic        Req,
   input  logic        md_busy,
   output logic        md_start,
   output logic [31:0] md_instr,
   output logic        stall_D,
   output logic        proto_err
);

   // The shadow counter is 4 bits wide.
   if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
      $error("MUL_CYCLES must be 1..15");
   end
   if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
      $error("DIV_CYCLES must be 1..15");
   end

   md_class_t e_cls, d_cls;
   md_state_e state, state_n;
   logic [3:0] cnt, cnt_n;
   logic       issued;
   logic       started_q;
   logic       err_now;

   md_class u_cls_e (.instr(E_instr), .cls(e_cls));
   md_class u_cls_d (.instr(D_instr), .cls(d_cls));

   // Reset gates the outputs combinationally so nothing leaks to the unit
   // while reset is held, even though the registers already sit at reset.
   assign md_instr = (reset && E_valid && !Req) ? E_instr : 32'h0;
   assign md_start = reset && (state == ST_IDLE) && E_valid && e_cls.is_md_op &&
                     !Req && !issued && !md_busy;
   assign stall_D  = d_cls.is_hl_acc && (md_start || md_busy || state == ST_BUSY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         ST_IDLE: begin
            if (md_start) begin
               state_n = ST_BUSY;
               cnt_n   = e_cls.is_mul ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
            end
         end
         ST_BUSY: begin
            // The unit freezes under Req, so the shadow does too.
            if (!Req) begin
               if (cnt == 4'd1) begin
                  state_n = ST_IDLE;
                  cnt_n   = 4'd0;
               end else begin
                  cnt_n = cnt - 4'd1;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   // a) unit failed to go busy after a start
   // b) unit dropped busy before the shadow reached its last cycle
   // c) unit busy while we think it is idle, outside the start handoff
   assign err_now = (started_q && !md_busy) ||
                    (state == ST_BUSY && cnt > 4'd1 && !md_busy) ||
                    (state == ST_IDLE && md_busy && !started_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issued    <= 1'b0;
         started_q <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         started_q <= md_start;
         // Set wins over clear: one start per E instance even if E advances
         // in the same cycle.
         if (md_start)
            issued <= 1'b1;
         else if (!E_hold)
            issued <= 1'b0;
         if (err_now)
            proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
module tb_muldiv_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] E_instr, D_instr;
   logic        E_valid, E_hold, Req, md_busy;
   logic        md_start, stall_D, proto_err;
   logic [31:0] md_instr;

   muldiv_issue_ctrl dut (
      .clk(clk), .reset(reset), .E_instr(E_instr), .E_valid(E_valid),
      .E_hold(E_hold), .D_instr(D_instr), .Req(Req), .md_busy(md_busy),
      .md_start(md_start), .md_instr(md_instr), .stall_D(stall_D),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: remaining busy cycles of the issued op, the unit's own
   // remaining cycles, and the flags the rules talk about
   int m_rem, m_unit;
   bit m_issued, m_proto, m_prev_start;
   bit kill_busy, force_busy;
   bit e_start, e_stall;
   logic [31:0] e_instr;
   int n_start, n_stall;

   function automatic logic [31:0] rtype(input logic [5:0] f);
      return {6'd0, 5'd8, 5'd9, 5'd10, 5'd0, f};
   endfunction

   function automatic bit is_md(input logic [31:0] i);
      return i[31:26] == 6'd0 && i[5:0] inside {6'h18, 6'h19, 6'h1a, 6'h1b};
   endfunction

   function automatic bit is_hl(input logic [31:0] i);
      return is_md(i) || (i[31:26] == 6'd0 && i[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13});
   endfunction

   function automatic int lat(input logic [31:0] i);
      return (i[5:0] == 6'h18 || i[5:0] == 6'h19) ? 5 : 10;
   endfunction

   function automatic logic [31:0] pick();
      logic [5:0] tbl [9] = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12, 6'h11, 6'h13, 6'h21};
      int k = $urandom_range(0, 10);
      if (k < 9) return rtype(tbl[k]);
      return $urandom;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one cycle: inputs already set after a negedge
   task automatic step();
      if (!reset) begin
         m_rem = 0; m_unit = 0; m_issued = 0; m_proto = 0; m_prev_start = 0;
      end
      md_busy = force_busy ? 1'b1 : (kill_busy ? 1'b0 : (m_unit > 0));
      #1;
      e_start = reset && m_rem == 0 && E_valid && is_md(E_instr) && !Req &&
                !m_issued && !md_busy;
      e_instr = (reset && E_valid && !Req) ? E_instr : 32'h0;
      e_stall = is_hl(D_instr) && (e_start || md_busy || m_rem > 0);
      chk("md_start", md_start, e_start);
      chk("md_instr", md_instr, e_instr);
      chk("stall_D", stall_D, e_stall);
      chk("proto_err", proto_err, m_proto);
      chk("cnt", dut.cnt, m_rem);
      n_start += int'(md_start);
      n_stall += int'(stall_D);
      @(posedge clk);
      if (reset) begin
         if ((m_prev_start && !md_busy) || (m_rem > 1 && !md_busy) ||
             (m_rem == 0 && md_busy && !m_prev_start))
            m_proto = 1;
         if (m_rem == 0) begin
            if (e_start) m_rem = lat(E_instr);
         end else if (!Req) m_rem--;
         if (e_start) m_issued = 1;
         else if (!E_hold) m_issued = 0;
         if (e_start) m_unit = lat(E_instr);
         else if (m_unit > 0 && !Req) m_unit--;
         m_prev_start = e_start;
      end
      @(negedge clk);
   endtask

   task automatic idle_in();
      E_instr = 32'h0; E_valid = 0; E_hold = 0; D_instr = 32'h0; Req = 0;
      kill_busy = 0; force_busy = 0;
   endtask

   task automatic do_reset();
      reset = 0; idle_in();
      repeat (2) step();
      reset = 1;
   endtask

   initial begin
      reset = 0; idle_in(); md_busy = 0;
      @(negedge clk);
      // reset state
      step();
      chk("rst_proto", proto_err, 1'b0);
      chk("rst_start", md_start, 1'b0);
      reset = 1;

      // 1: mult, mfhi in D
      n_start = 0; n_stall = 0;
      E_instr = rtype(6'h18); E_valid = 1; D_instr = rtype(6'h10);
      step();
      E_valid = 0;
      repeat (8) step();
      chk("t1_starts", n_start, 1);
      chk("t1_stall", n_stall, 6);
      chk("t1_proto", proto_err, 1'b0);

      // 2: divu, mflo in D, then addu never stalls
      n_start = 0; n_stall = 0;
      E_instr = rtype(6'h1b); E_valid = 1; D_instr = rtype(6'h12);
      step();
      chk("t2_cnt10", dut.cnt, 4'd10);
      E_valid = 0;
      repeat (12) step();
      chk("t2_stall", n_stall, 11);
      n_stall = 0;
      E_instr = rtype(6'h1a); E_valid = 1; D_instr = rtype(6'h21);
      step();
      E_valid = 0;
      repeat (12) step();
      chk("t2_addu", n_stall, 0);

      // 3: Req for 3 cycles two cycles into a div
      n_stall = 0;
      E_instr = rtype(6'h1a); E_valid = 1; D_instr = rtype(6'h12);
      step();
      E_valid = 0;
      repeat (2) step();
      Req = 1;
      repeat (3) step();
      Req = 0;
      repeat (12) step();
      chk("t3_window", n_stall, 14);

      // 4: Req with mthi / mult in E
      n_start = 0;
      Req = 1; E_valid = 1; E_instr = rtype(6'h11);
      step();
      chk("t4_mthi_instr", md_instr, 32'h0);
      E_instr = rtype(6'h18);
      step();
      chk("t4_mult_start", n_start, 0);
      Req = 0; E_valid = 0;
      step();

      // 5: held mult starts once; busy stuck low trips the sticky error
      n_start = 0;
      E_instr = rtype(6'h18); E_valid = 1; E_hold = 1; kill_busy = 1;
      repeat (4) step();
      E_hold = 0; E_valid = 0;
      repeat (8) step();
      chk("t5_starts", n_start, 1);
      chk("t5_err", proto_err, 1'b1);
      kill_busy = 0;
      repeat (3) step();
      chk("t5_sticky", proto_err, 1'b1);

      // 6: reset mid-mult at cnt==3
      do_reset();
      E_instr = rtype(6'h18); E_valid = 1; D_instr = rtype(6'h10);
      step();
      E_valid = 0;
      repeat (2) step();
      chk("t6_cnt3", dut.cnt, 4'd3);
      reset = 0; E_valid = 1;
      step();
      chk("t6_stall", stall_D, 1'b0);
      chk("t6_proto", proto_err, 1'b0);
      chk("t6_cnt", dut.cnt, 4'd0);
      reset = 1; idle_in();
      step();

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         E_instr    = pick();
         D_instr    = pick();
         E_valid    = ($urandom_range(0, 9) < 7);
         E_hold     = ($urandom_range(0, 9) < 3);
         Req        = ($urandom_range(0, 99) < 8);
         kill_busy  = ($urandom_range(0, 99) < 2);
         force_busy = ($urandom_range(0, 99) < 2);
         reset      = ($urandom_range(0, 99) != 0);
         step();
      end
      reset = 1; idle_in();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
